// File: rtl/cpu_ctrl_pkg.sv
// Opcode constants and FSM state encoding shared between the controller and the ALU.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    HALT   = 2'd3
  } state_t;

  localparam logic [3:0] OP_NOT  = 4'h0;
  localparam logic [3:0] OP_XOR  = 4'h1;
  localparam logic [3:0] OP_OR   = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_ADD  = 4'h5;
  localparam logic [3:0] OP_RR   = 4'h6;
  localparam logic [3:0] OP_RL   = 4'h7;
  localparam logic [3:0] OP_DEC  = 4'h8;
  localparam logic [3:0] OP_INC  = 4'h9;
  localparam logic [3:0] OP_LD   = 4'hA;
  localparam logic [3:0] OP_ST   = 4'hB;
  localparam logic [3:0] OP_NOP  = 4'hC;
  localparam logic [3:0] OP_SRST = 4'hD;
  localparam logic [3:0] OP_JMP  = 4'hE;
  localparam logic [3:0] OP_HLT  = 4'hF;

  localparam logic [7:0] IR_RESET = {OP_NOP, 4'h0};

endpackage

// File: rtl/cpu_ctrl.sv
// Three-cycle FETCH/DECODE/EXEC controller for a 4-bit accumulator CPU.
module cpu_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned PWIDTH = 8,
  parameter int unsigned IWIDTH = 4
) (
  input  logic              CLK,
  input  logic              RST,
  output logic [PWIDTH-1:0] PC_OUT,
  input  logic [7:0]        INSTR_IN,
  output logic [IWIDTH-1:0] ALU_INSTR,
  output logic              ALU_CIN,
  output logic              ALU_BIN,
  input  logic              ALU_COUT,
  input  logic              ALU_BOUT,
  output logic              ACC_LD,
  output logic              ACC_CLR,
  output logic [IWIDTH-1:0] MEM_ADDR,
  output logic              MEM_WE,
  output logic              HALTED
);

  state_t              state_q, state_d;
  logic [PWIDTH-1:0]   pc_q, pc_d;
  logic [7:0]          ir_q, ir_d;
  logic                c_q, c_d;
  logic                b_q, b_d;
  logic [3:0]          op;
  logic                exec_live;

  assign op = ir_q[7:4];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    c_d     = c_q;
    b_d     = b_q;
    unique case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        ir_d    = INSTR_IN;
        state_d = EXEC;
      end
      EXEC: begin
        state_d = FETCH;
        pc_d    = pc_q + PWIDTH'(1);
        case (op)
          OP_ADD, OP_INC: c_d = ALU_COUT;
          OP_SUB, OP_DEC: b_d = ALU_BOUT;
          OP_SRST: begin
            c_d  = 1'b0;
            b_d  = 1'b0;
            pc_d = '0;
          end
          OP_JMP: pc_d = PWIDTH'(ir_q[3:0]);
          OP_HLT: begin
            pc_d    = pc_q;
            state_d = HALT;
          end
          default: ;
        endcase
      end
      HALT: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= FETCH;
      pc_q    <= '0;
      ir_q    <= IR_RESET;
      c_q     <= 1'b0;
      b_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      c_q     <= c_d;
      b_q     <= b_d;
    end
  end

  // Strobes decode straight from IR so a reset landing mid-EXEC kills them that same cycle.
  assign exec_live = (state_q == EXEC) && !RST;

  assign ACC_LD    = exec_live && (op <= OP_LD);
  assign ACC_CLR   = exec_live && (op == OP_SRST);
  assign MEM_WE    = exec_live && (op == OP_ST);
  assign ALU_INSTR = (exec_live && (op <= OP_LD)) ? IWIDTH'(op) : IWIDTH'(OP_NOP);
  assign MEM_ADDR  = IWIDTH'(ir_q[3:0]);
  assign PC_OUT    = pc_q;
  assign ALU_CIN   = c_q;
  assign ALU_BIN   = b_q;
  assign HALTED    = (state_q == HALT);

endmodule

// File: tb/tb_cpu_ctrl.sv
// Self-checking bench for cpu_ctrl: instruction table with scoreboard plus halt/reset/wrap sequences.
module tb_cpu_ctrl;

  typedef struct {
    logic [7:0] pc;
    logic [7:0] instr;
    logic       cout;
    logic       bout;
    logic       ld;
    logic       clr;
    logic       we;
    logic [3:0] alu;
    logic [3:0] addr;
    logic [7:0] npc;
    logic       cin;
    logic       bin;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [7:0] pc_out;
  logic [7:0] instr_in;
  logic [3:0] alu_instr;
  logic       alu_cin, alu_bin, alu_cout, alu_bout;
  logic       acc_ld, acc_clr, mem_we, halted;
  logic [3:0] mem_addr;
  logic [7:0] prog [256];
  logic       done;

  int checks;
  int failures;

  vec_t vecs [17];
  vec_t sb [$];

  cpu_ctrl #(.PWIDTH(8), .IWIDTH(4)) dut (
    .CLK      (clk),
    .RST      (rst),
    .PC_OUT   (pc_out),
    .INSTR_IN (instr_in),
    .ALU_INSTR(alu_instr),
    .ALU_CIN  (alu_cin),
    .ALU_BIN  (alu_bin),
    .ALU_COUT (alu_cout),
    .ALU_BOUT (alu_bout),
    .ACC_LD   (acc_ld),
    .ACC_CLR  (acc_clr),
    .MEM_ADDR (mem_addr),
    .MEM_WE   (mem_we),
    .HALTED   (halted)
  );

  assign instr_in = prog[pc_out];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    alu_cout = 1'b0;
    alu_bout = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_ld"},  {31'b0, acc_ld},  32'd0);
    chk({nm, "_clr"}, {31'b0, acc_clr}, 32'd0);
    chk({nm, "_we"},  {31'b0, mem_we},  32'd0);
    chk({nm, "_alu"}, {28'b0, alu_instr}, 32'hC);
  endtask

  function automatic vec_t mk(int pc, int instr, int co, int bo, int ld, int clr, int we,
                              int alu, int addr, int npc, int ci, int bi);
    vec_t m;
    m.pc = 8'(pc);   m.instr = 8'(instr);
    m.cout = 1'(co); m.bout = 1'(bo);
    m.ld = 1'(ld);   m.clr = 1'(clr);     m.we = 1'(we);
    m.alu = 4'(alu); m.addr = 4'(addr);
    m.npc = 8'(npc); m.cin = 1'(ci);      m.bin = 1'(bi);
    return m;
  endfunction

  always @(negedge clk) begin
    if (!done)
      chk("mutex", {31'b0, ($countones({acc_ld, acc_clr, mem_we}) <= 1)}, 32'd1);
  end

  initial begin
    vec_t e;
    checks = 0;
    failures = 0;
    done = 1'b0;
    rst = 1'b1;
    alu_cout = 1'b0;
    alu_bout = 1'b0;
    for (int i = 0; i < 256; i++) prog[i] = 8'hC0;

    //             pc   ins  co bo ld cl we alu addr npc  ci bi
    vecs[0]  = mk(8'h00, 8'h53, 1, 0, 1, 0, 0, 4'h5, 4'h3, 8'h01, 1, 0);
    vecs[1]  = mk(8'h01, 8'h12, 0, 0, 1, 0, 0, 4'h1, 4'h2, 8'h02, 1, 0);
    vecs[2]  = mk(8'h02, 8'h40, 0, 1, 1, 0, 0, 4'h4, 4'h0, 8'h03, 1, 1);
    vecs[3]  = mk(8'h03, 8'hA7, 0, 0, 1, 0, 0, 4'hA, 4'h7, 8'h04, 1, 1);
    vecs[4]  = mk(8'h04, 8'hB9, 0, 0, 0, 0, 1, 4'hC, 4'h9, 8'h05, 1, 1);
    vecs[5]  = mk(8'h05, 8'hC5, 1, 1, 0, 0, 0, 4'hC, 4'h5, 8'h06, 1, 1);
    vecs[6]  = mk(8'h06, 8'h90, 0, 1, 1, 0, 0, 4'h9, 4'h0, 8'h07, 0, 1);
    vecs[7]  = mk(8'h07, 8'h81, 1, 0, 1, 0, 0, 4'h8, 4'h1, 8'h08, 0, 0);
    vecs[8]  = mk(8'h08, 8'h50, 1, 0, 1, 0, 0, 4'h5, 4'h0, 8'h09, 1, 0);
    vecs[9]  = mk(8'h09, 8'h4F, 0, 1, 1, 0, 0, 4'h4, 4'hF, 8'h0A, 1, 1);
    vecs[10] = mk(8'h0A, 8'hD0, 0, 0, 0, 1, 0, 4'hC, 4'h0, 8'h00, 0, 0);
    vecs[11] = mk(8'h00, 8'hE7, 0, 0, 0, 0, 0, 4'hC, 4'h7, 8'h07, 0, 0);
    vecs[12] = mk(8'h07, 8'h3E, 1, 1, 1, 0, 0, 4'h3, 4'hE, 8'h08, 0, 0);
    vecs[13] = mk(8'h08, 8'h62, 1, 1, 1, 0, 0, 4'h6, 4'h2, 8'h09, 0, 0);
    vecs[14] = mk(8'h09, 8'h0A, 1, 1, 1, 0, 0, 4'h0, 4'hA, 8'h0A, 0, 0);
    vecs[15] = mk(8'h0A, 8'h73, 1, 0, 1, 0, 0, 4'h7, 4'h3, 8'h0B, 0, 0);
    vecs[16] = mk(8'h0B, 8'h2C, 0, 1, 1, 0, 0, 4'h2, 4'hC, 8'h0C, 0, 0);

    // Reset state
    do_reset();
    chk("rst_pc", {24'b0, pc_out}, 32'h00);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_cin", {31'b0, alu_cin}, 32'd0);
    chk("rst_bin", {31'b0, alu_bin}, 32'd0);
    chk("rst_addr", {28'b0, mem_addr}, 32'h0);
    chk_idle("rst");

    // Instruction table through the scoreboard
    foreach (vecs[i]) begin
      chk("fetch_pc", {24'b0, pc_out}, {24'b0, vecs[i].pc});
      prog[pc_out] = vecs[i].instr;
      alu_cout = vecs[i].cout;
      alu_bout = vecs[i].bout;
      sb.push_back(vecs[i]);
      chk_idle("fetch");
      step();
      chk_idle("decode");
      step();
      if (sb.size() == 0) begin
        chk("sb_empty", 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        chk("ex_ld",   {31'b0, acc_ld},    {31'b0, e.ld});
        chk("ex_clr",  {31'b0, acc_clr},   {31'b0, e.clr});
        chk("ex_we",   {31'b0, mem_we},    {31'b0, e.we});
        chk("ex_alu",  {28'b0, alu_instr}, {28'b0, e.alu});
        chk("ex_addr", {28'b0, mem_addr},  {28'b0, e.addr});
        step();
        chk("next_pc", {24'b0, pc_out},  {24'b0, e.npc});
        chk("cin",     {31'b0, alu_cin}, {31'b0, e.cin});
        chk("bin",     {31'b0, alu_bin}, {31'b0, e.bin});
        chk("not_halted", {31'b0, halted}, 32'd0);
      end
    end
    chk("sb_drained", sb.size(), 32'd0);

    // Program {A3,54,B5,F0} runs to HALT
    do_reset();
    for (int i = 0; i < 256; i++) prog[i] = 8'hC0;
    prog[0] = 8'hA3; prog[1] = 8'h54; prog[2] = 8'hB5; prog[3] = 8'hF0;
    repeat (2) step();
    chk("p_ld0",   {31'b0, acc_ld}, 32'd1);
    chk("p_addr0", {28'b0, mem_addr}, 32'h3);
    chk("p_alu0",  {28'b0, alu_instr}, 32'hA);
    repeat (3) step();
    chk("p_ld1",   {31'b0, acc_ld}, 32'd1);
    chk("p_alu1",  {28'b0, alu_instr}, 32'h5);
    repeat (3) step();
    chk("p_we2",   {31'b0, mem_we}, 32'd1);
    chk("p_ld2",   {31'b0, acc_ld}, 32'd0);
    chk("p_addr2", {28'b0, mem_addr}, 32'h5);
    repeat (3) step();
    chk_idle("p_hlt_ex");
    step();
    chk("p_halted", {31'b0, halted}, 32'd1);
    chk("p_pc",     {24'b0, pc_out}, 32'h03);
    repeat (6) step();
    chk("p_halted_hold", {31'b0, halted}, 32'd1);
    chk("p_pc_hold",     {24'b0, pc_out}, 32'h03);
    chk_idle("p_halt");

    // Reset during EXEC of ST with both flags set
    do_reset();
    chk("rh_halted", {31'b0, halted}, 32'd0);
    prog[0] = 8'h50; prog[1] = 8'h40; prog[2] = 8'hB5;
    alu_cout = 1'b1;
    alu_bout = 1'b1;
    repeat (6) step();
    chk("rs_cin_set", {31'b0, alu_cin}, 32'd1);
    chk("rs_bin_set", {31'b0, alu_bin}, 32'd1);
    repeat (2) step();
    chk("rs_we_pre", {31'b0, mem_we}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rs_we_kill", {31'b0, mem_we}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rs_pc",  {24'b0, pc_out}, 32'h00);
    chk("rs_cin", {31'b0, alu_cin}, 32'd0);
    chk("rs_bin", {31'b0, alu_bin}, 32'd0);

    // PC wrap at 0xFF, then JMP from 0
    do_reset();
    for (int i = 0; i < 256; i++) prog[i] = 8'hC0;
    repeat (255 * 3) step();
    chk("wrap_ff", {24'b0, pc_out}, 32'hFF);
    prog[0] = 8'hE7;
    repeat (3) step();
    chk("wrap_00", {24'b0, pc_out}, 32'h00);
    repeat (3) step();
    chk("jmp_07", {24'b0, pc_out}, 32'h07);

    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
